// File: rtl/a10_xcvr_reset_pkg.sv
// a10_xcvr_reset_pkg: shared types for the transceiver reset sequencer.
// State enums and the delay-counter width helper.
package a10_xcvr_reset_pkg;

  typedef enum logic [1:0] {
    TX_RESET      = 2'd0,
    TX_ANALOG_REL = 2'd1,
    TX_READY      = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_RESET    = 2'd0,
    RX_WAIT_LTD = 2'd1,
    RX_READY    = 2'd2
  } rx_state_t;

  // Wide enough for DELAY-1, never narrower than one bit.
  function automatic int cnt_width(input int delay);
    return $clog2(delay < 2 ? 2 : delay);
  endfunction

endpackage

// File: rtl/a10_xcvr_stable_filter.sv
// a10_xcvr_stable_filter: asserts stable once din held high DELAY
// consecutive enabled cycles; any low or disabled cycle restarts it.
module a10_xcvr_stable_filter #(
  parameter int DELAY = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic din,
  output logic stable
);

  import a10_xcvr_reset_pkg::*;

  localparam int         W    = cnt_width(DELAY);
  localparam logic [W-1:0] LOAD = W'(DELAY - 1);

  logic [W-1:0] cnt;

  // Reload on any break in lock, count down and hold at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                cnt <= LOAD;
    else if (!enable || !din) cnt <= LOAD;
    else if (cnt != '0)       cnt <= cnt - 1'b1;
  end

  assign stable = enable && din && (cnt == '0);

endmodule

// File: rtl/areset_synchronizer.sv
// areset_synchronizer: async-assert, sync-deassert reset bridge.
// Output sreset is active-high regardless of input polarity.
module areset_synchronizer #(
  parameter logic ACTIVE_LEVEL = 1'b0,
  parameter int   EXTRA_STAGES = 0
) (
  input  logic clk,
  input  logic areset,
  output logic sreset
);

  localparam int N = 2 + EXTRA_STAGES;

  logic         arst;
  logic [N-1:0] chain;

  assign arst = (areset == ACTIVE_LEVEL);

  // Fill with ones on assertion, shift zeros in once released.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) chain <= '1;
    else      chain <= {chain[N-2:0], 1'b0};
  end

  assign sreset = chain[N-1];

endmodule

// File: rtl/ff_synchronizer.sv
// ff_synchronizer: multi-flop synchronizer for slow async levels.
// Latency is 2+EXTRA_STAGES clocks; reset value is configurable.
module ff_synchronizer #(
  parameter int               WIDTH        = 1,
  parameter int               EXTRA_STAGES = 0,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  localparam int N = 2 + EXTRA_STAGES;

  logic [N-1:0][WIDTH-1:0] chain;

  // Plain shift chain; held at the pessimistic value in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) chain <= {N{RESET_VAL}};
    else       chain <= {chain[N-2:0], data_in};
  end

  assign data_out = chain[N-1];

endmodule

// File: rtl/a10_xcvr_reset_sequencer.sv
// a10_xcvr_reset_sequencer: TX/RX reset sequencing for one
// Arria 10 channel, with independent TX and RX state machines.
module a10_xcvr_reset_sequencer #(
  parameter int TX_DIG_DELAY = 20,
  parameter int RX_DIG_DELAY = 20,
  parameter int SYNC_STAGES  = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pll_powerdown,
  input  logic pll_locked,
  input  logic tx_cal_busy,
  input  logic rx_cal_busy,
  input  logic rx_is_lockedtodata,
  output logic tx_analogreset,
  output logic tx_digitalreset,
  output logic rx_analogreset,
  output logic rx_digitalreset,
  output logic tx_ready,
  output logic rx_ready
);

  import a10_xcvr_reset_pkg::*;

  localparam int            TW      = cnt_width(TX_DIG_DELAY);
  localparam logic [TW-1:0] TX_LOAD = TW'(TX_DIG_DELAY - 1);

  logic sreset;
  logic pll_locked_s;
  logic tx_cal_busy_s;
  logic rx_cal_busy_s;
  logic rx_is_lockedtodata_s;

  areset_synchronizer #(
    .ACTIVE_LEVEL (1'b0),
    .EXTRA_STAGES (0)
  ) u_rst_sync (
    .clk    (clk),
    .areset (reset_n),
    .sreset (sreset)
  );

  ff_synchronizer #(
    .WIDTH (1), .EXTRA_STAGES (SYNC_STAGES), .RESET_VAL (1'b0)
  ) u_sync_lock (
    .clk (clk), .reset (sreset),
    .data_in (pll_locked), .data_out (pll_locked_s)
  );

  ff_synchronizer #(
    .WIDTH (1), .EXTRA_STAGES (SYNC_STAGES), .RESET_VAL (1'b1)
  ) u_sync_txbusy (
    .clk (clk), .reset (sreset),
    .data_in (tx_cal_busy), .data_out (tx_cal_busy_s)
  );

  ff_synchronizer #(
    .WIDTH (1), .EXTRA_STAGES (SYNC_STAGES), .RESET_VAL (1'b1)
  ) u_sync_rxbusy (
    .clk (clk), .reset (sreset),
    .data_in (rx_cal_busy), .data_out (rx_cal_busy_s)
  );

  ff_synchronizer #(
    .WIDTH (1), .EXTRA_STAGES (SYNC_STAGES), .RESET_VAL (1'b0)
  ) u_sync_ltd (
    .clk (clk), .reset (sreset),
    .data_in (rx_is_lockedtodata), .data_out (rx_is_lockedtodata_s)
  );

  tx_state_t     tx_state, tx_next;
  logic [TW-1:0] tx_cnt, tx_cnt_next;
  logic          tx_abort;

  assign tx_abort = pll_powerdown || !pll_locked_s || tx_cal_busy_s;

  // TX state and delay counter registers.
  always_ff @(posedge clk or posedge sreset) begin
    if (sreset) begin
      tx_state <= TX_RESET;
      tx_cnt   <= TX_LOAD;
    end else begin
      tx_state <= tx_next;
      tx_cnt   <= tx_cnt_next;
    end
  end

  // TX next state; abort beats counter expiry, counter reloads on exit.
  always_comb begin
    tx_next     = tx_state;
    tx_cnt_next = tx_cnt;
    unique case (tx_state)
      TX_RESET: begin
        tx_cnt_next = TX_LOAD;
        if (!tx_abort) tx_next = TX_ANALOG_REL;
      end
      TX_ANALOG_REL: begin
        if (tx_abort) begin
          tx_next     = TX_RESET;
          tx_cnt_next = TX_LOAD;
        end else if (tx_cnt == '0) begin
          tx_next = TX_READY;
        end else begin
          tx_cnt_next = tx_cnt - 1'b1;
        end
      end
      TX_READY: begin
        if (tx_abort) begin
          tx_next     = TX_RESET;
          tx_cnt_next = TX_LOAD;
        end
      end
      default: begin
        tx_next     = TX_RESET;
        tx_cnt_next = TX_LOAD;
      end
    endcase
  end

  // TX outputs registered from the current state.
  always_ff @(posedge clk or posedge sreset) begin
    if (sreset) begin
      tx_analogreset  <= 1'b1;
      tx_digitalreset <= 1'b1;
      tx_ready        <= 1'b0;
    end else begin
      tx_analogreset  <= !(tx_state == TX_ANALOG_REL ||
                           tx_state == TX_READY);
      tx_digitalreset <= (tx_state != TX_READY);
      tx_ready        <= (tx_state == TX_READY);
    end
  end

  rx_state_t rx_state, rx_next;
  logic      rx_stable;

  a10_xcvr_stable_filter #(
    .DELAY (RX_DIG_DELAY)
  ) u_ltd_filter (
    .clk    (clk),
    .reset  (sreset),
    .enable (rx_state == RX_WAIT_LTD),
    .din    (rx_is_lockedtodata_s),
    .stable (rx_stable)
  );

  // RX state register.
  always_ff @(posedge clk or posedge sreset) begin
    if (sreset) rx_state <= RX_RESET;
    else        rx_state <= rx_next;
  end

  // RX next state; calibration busy overrides everything.
  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_RESET: begin
        if (!rx_cal_busy_s) rx_next = RX_WAIT_LTD;
      end
      RX_WAIT_LTD: begin
        if (rx_cal_busy_s)  rx_next = RX_RESET;
        else if (rx_stable) rx_next = RX_READY;
      end
      RX_READY: begin
        if (rx_cal_busy_s)              rx_next = RX_RESET;
        else if (!rx_is_lockedtodata_s) rx_next = RX_WAIT_LTD;
      end
      default: rx_next = RX_RESET;
    endcase
  end

  // RX outputs registered from the current state.
  always_ff @(posedge clk or posedge sreset) begin
    if (sreset) begin
      rx_analogreset  <= 1'b1;
      rx_digitalreset <= 1'b1;
      rx_ready        <= 1'b0;
    end else begin
      rx_analogreset  <= !(rx_state == RX_WAIT_LTD ||
                           rx_state == RX_READY);
      rx_digitalreset <= (rx_state != RX_READY);
      rx_ready        <= (rx_state == RX_READY);
    end
  end

endmodule

// File: tb/tb_a10_xcvr_reset_sequencer.sv
// tb_a10_xcvr_reset_sequencer: directed plus random stimulus,
// checked against a run-length reference model of the sequencing rules.
module tb_a10_xcvr_reset_sequencer;

  localparam int TXD = 4;
  localparam int RXD = 8;
  localparam int SS  = 1;
  localparam int SL  = 2 + SS;

  logic clk = 1'b0;
  logic reset_n;
  logic pll_powerdown;
  logic pll_locked;
  logic tx_cal_busy;
  logic rx_cal_busy;
  logic rx_is_lockedtodata;
  logic tx_analogreset;
  logic tx_digitalreset;
  logic rx_analogreset;
  logic rx_digitalreset;
  logic tx_ready;
  logic rx_ready;

  a10_xcvr_reset_sequencer #(
    .TX_DIG_DELAY (TXD),
    .RX_DIG_DELAY (RXD),
    .SYNC_STAGES  (SS)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .pll_powerdown      (pll_powerdown),
    .pll_locked         (pll_locked),
    .tx_cal_busy        (tx_cal_busy),
    .rx_cal_busy        (rx_cal_busy),
    .rx_is_lockedtodata (rx_is_lockedtodata),
    .tx_analogreset     (tx_analogreset),
    .tx_digitalreset    (tx_digitalreset),
    .rx_analogreset     (rx_analogreset),
    .rx_digitalreset    (rx_digitalreset),
    .tx_ready           (tx_ready),
    .rx_ready           (rx_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [2:0] got,
                     input logic [2:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. tx_run: consecutive enabled edges the TX go
  // condition held (0 = reset, 1..TXD = analog released, >TXD = ready).
  // rx_ph: 0 reset, 1 waiting for lock, 2 ready; rx_hi: lock run length.
  int rn_run = 0;
  int tx_run = 0;
  int rx_ph  = 0;
  int rx_hi  = 0;
  logic [2:0]    exp_tx = 3'b110;
  logic [2:0]    exp_rx = 3'b110;
  logic [SL-1:0] lk_l = '0;
  logic [SL-1:0] tb_l = '1;
  logic [SL-1:0] rb_l = '1;
  logic [SL-1:0] ld_l = '0;

  task automatic model_reset();
    exp_tx = 3'b110;
    exp_rx = 3'b110;
    tx_run = 0;
    rx_ph  = 0;
    rx_hi  = 0;
    lk_l   = '0;
    tb_l   = '1;
    rb_l   = '1;
    ld_l   = '0;
  endtask

  always @(negedge reset_n) begin
    rn_run = 0;
    model_reset();
  end

  always @(posedge clk) begin
    logic lk, tb, rb, ld;
    if (rn_run < 2) begin
      model_reset();
    end else begin
      exp_tx = {tx_run == 0, tx_run <= TXD, tx_run > TXD};
      exp_rx = {rx_ph == 0, rx_ph != 2, rx_ph == 2};
      lk = lk_l[SL-1];
      tb = tb_l[SL-1];
      rb = rb_l[SL-1];
      ld = ld_l[SL-1];
      if (!pll_powerdown && lk && !tb) begin
        if (tx_run < 1000) tx_run++;
      end else begin
        tx_run = 0;
      end
      if (rb) begin
        rx_ph = 0;
      end else if (rx_ph == 0) begin
        rx_ph = 1;
        rx_hi = 0;
      end else if (rx_ph == 1) begin
        rx_hi = ld ? rx_hi + 1 : 0;
        if (rx_hi >= RXD) rx_ph = 2;
      end else if (!ld) begin
        rx_ph = 1;
        rx_hi = 0;
      end
      lk_l = {lk_l[SL-2:0], pll_locked};
      tb_l = {tb_l[SL-2:0], tx_cal_busy};
      rb_l = {rb_l[SL-2:0], rx_cal_busy};
      ld_l = {ld_l[SL-2:0], rx_is_lockedtodata};
    end
    if (reset_n === 1'b1) begin
      if (rn_run < 1000) rn_run++;
    end else begin
      rn_run = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("tx_out", {tx_analogreset, tx_digitalreset, tx_ready}, exp_tx);
      chk("rx_out", {rx_analogreset, rx_digitalreset, rx_ready}, exp_rx);
    end
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("async_tx", {tx_analogreset, tx_digitalreset, tx_ready}, 3'b110);
    chk("async_rx", {rx_analogreset, rx_digitalreset, rx_ready}, 3'b110);
  endtask

  initial begin
    int k;
    reset_n            = 1'b0;
    pll_powerdown      = 1'b1;
    pll_locked         = 1'b0;
    tx_cal_busy        = 1'b1;
    rx_cal_busy        = 1'b1;
    rx_is_lockedtodata = 1'b0;
    step(5);
    reset_n = 1'b1;
    step(4);

    pll_powerdown = 1'b0;
    pll_locked    = 1'b1;
    tx_cal_busy   = 1'b0;
    step(15);

    pll_locked = 1'b0;
    step(6);
    pll_locked = 1'b1;
    step(15);

    rx_cal_busy        = 1'b0;
    step(5);
    rx_is_lockedtodata = 1'b1;
    step(5);
    rx_is_lockedtodata = 1'b0;
    step(1);
    rx_is_lockedtodata = 1'b1;
    step(14);
    rx_is_lockedtodata = 1'b0;
    step(5);
    rx_is_lockedtodata = 1'b1;
    step(14);

    pll_powerdown = 1'b1;
    step(5);
    pll_powerdown = 1'b0;
    k = 0;
    while (tx_analogreset !== 1'b0 && k < 30) begin
      step(1);
      k++;
    end
    chk("tx_arel_seen", {2'b00, tx_analogreset}, 3'b000);
    async_reset();
    step(3);
    reset_n = 1'b1;
    step(20);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0)
        pll_powerdown = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0)
        pll_locked = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0)
        tx_cal_busy = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0)
        rx_cal_busy = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 11) == 0)
        rx_is_lockedtodata = ($urandom_range(0, 4) != 0);
      if (reset_n == 1'b0) begin
        if ($urandom_range(0, 2) == 0) reset_n = 1'b1;
        step(1);
      end else if ($urandom_range(0, 399) == 0) begin
        async_reset();
        step(1);
      end else begin
        step(1);
      end
    end

    reset_n = 1'b1;
    step(30);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
